timer_multi_controller: RTL



---
 rtl/timer_multi_controller_pkg.sv | 28 ++
 rtl/timer_multi_controller_channel.sv | 56 +++++
 rtl/timer_multi_controller.sv | 75 +++++++
 3 files changed

// File: rtl/timer_multi_controller_pkg.sv
// timer_multi_controller_pkg: register map, CSR bit positions and bus macro defaults for the multi-channel timer
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif
`ifndef TMR_DIV
`define TMR_DIV 16
`endif

package timer_multi_controller_pkg;
    localparam int TMRX_STRIDE = 16;
    localparam logic [3:0] TMRX_CNT = 4'h0;
    localparam logic [3:0] TMRX_RLD = 4'h4;
    localparam logic [3:0] TMRX_CSR = 4'h8;
    localparam int CSR_EN = 0;
    localparam int CSR_MODE = 1;
    localparam int CSR_CHAIN = 2;
    localparam int CSR_IE = 7;
    localparam int CSR_PEND = 8;
    function automatic int tmrx_size(input int ch);
        return ch * TMRX_STRIDE;
    endfunction
endpackage

// File: rtl/timer_multi_controller_channel.sv
// timer_channel: one 32-bit down-counter with reload, CSR and sticky pending flag; CHAIN bit only under TMR_CHAIN_EN
module timer_channel
    import timer_multi_controller_pkg::*;
#(
    parameter bit CHAINABLE = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        chain_in,
    input  logic        wr_cnt,
    input  logic        wr_rld,
    input  logic        wr_csr,
    input  logic [31:0] wdata,
    output logic [31:0] cnt,
    output logic [31:0] rld,
    output logic [31:0] csr,
    output logic        expire,
    output logic        irq
);
    logic en, mode, ie, pend, chain, step;

`ifdef TMR_CHAIN_EN
    // chain select bit, writable only on channels that have a predecessor
    always_ff @(posedge clk)
        chain <= rst ? 1'b0 : (wr_csr && CHAINABLE) ? wdata[CSR_CHAIN] : chain;
`else
    assign chain = 1'b0;
`endif

    assign step   = (chain && CHAINABLE) ? chain_in : tick;
    assign expire = step & en & (cnt == 32'd1) & ~wr_cnt;
    assign irq    = ie & pend;
    assign csr    = {23'd0, pend, ie, 4'd0, chain, mode, en};

    // counter, reload and CSR state; a bus write to CNT overrides that cycle's step, expiry beats W1C
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= 32'd0;
            rld  <= 32'd0;
            en   <= 1'b0;
            mode <= 1'b0;
            ie   <= 1'b0;
            pend <= 1'b0;
        end else begin
            cnt  <= wr_cnt ? wdata
                  : (step && en && cnt != 32'd0) ? ((cnt == 32'd1) ? (mode ? rld : 32'd0) : cnt - 32'd1)
                  : cnt;
            rld  <= wr_rld ? wdata : rld;
            en   <= wr_csr ? wdata[CSR_EN] : en;
            mode <= wr_csr ? wdata[CSR_MODE] : mode;
            ie   <= wr_csr ? wdata[CSR_IE] : ie;
            pend <= expire | (pend & ~(wr_csr & wdata[CSR_PEND]));
        end
    end
endmodule

// File: rtl/timer_multi_controller.sv
// timer_multi_controller: CH down-counting timer channels on one prescaler behind the req/resp/fault bus; TMR_CHAIN_EN adds channel cascading
module timer_multi_controller
    import timer_multi_controller_pkg::*;
#(
    parameter int CH  = 4,
    parameter int DIV = `TMR_DIV
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic [CH-1:0]                 interrupt,
    output logic                          irq_any,
    input  logic [$clog2(tmrx_size(CH))-1:0] addr,
    input  logic                          w_rb,
    input  logic [`BUS_ACC_WIDTH-1:0]     acc,
    output logic [`BUS_WIDTH-1:0]         rdata,
    input  logic [`BUS_WIDTH-1:0]         wdata,
    input  logic                          req,
    output logic                          resp,
    output logic                          fault
);
    logic [16:0] pre;
    logic        tick, valid, hit;
    logic [3:0]  off;
    logic [7:0]  idx;
    logic [7:0]  exp_a;
    logic [31:0] cnt_a [8];
    logic [31:0] rld_a [8];
    logic [31:0] csr_a [8];

    assign tick    = (pre == 17'(DIV - 1));
    assign off     = {addr[3:2], 2'b00};
    assign idx     = 8'(addr >> 4);
    assign valid   = (addr[1:0] == 2'b00) && (acc == `BUS_ACC_4B) && (off != 4'hC) && (idx < 8'(CH));
    assign hit     = req & valid;
    assign fault   = req & ~valid;
    assign irq_any = |interrupt;

    // free-running prescaler, never restarted by bus traffic
    always_ff @(posedge clk)
        pre <= (rst || tick) ? 17'd0 : pre + 17'd1;

    // response strobe one cycle after an accepted request
    always_ff @(posedge clk)
        resp <= rst ? 1'b0 : hit;

    // read data captures pre-write register values and holds otherwise
    always_ff @(posedge clk)
        if (hit && !w_rb)
            rdata <= (off == TMRX_CNT) ? cnt_a[idx[2:0]] : (off == TMRX_RLD) ? rld_a[idx[2:0]] : csr_a[idx[2:0]];

    for (genvar i = 0; i < 8; i++) begin : g_ch
        if (i < CH) begin : g_on
            timer_channel #(.CHAINABLE(i > 0)) u_ch (
                .clk      (clk),
                .rst      (rst),
                .tick     (tick),
                .chain_in ((i == 0) ? 1'b0 : exp_a[(i + 7) % 8]),
                .wr_cnt   (hit && w_rb && idx == 8'(i) && off == TMRX_CNT),
                .wr_rld   (hit && w_rb && idx == 8'(i) && off == TMRX_RLD),
                .wr_csr   (hit && w_rb && idx == 8'(i) && off == TMRX_CSR),
                .wdata    (wdata),
                .cnt      (cnt_a[i]),
                .rld      (rld_a[i]),
                .csr      (csr_a[i]),
                .expire   (exp_a[i]),
                .irq      (interrupt[i])
            );
        end else begin : g_off
            assign cnt_a[i] = 32'd0;
            assign rld_a[i] = 32'd0;
            assign csr_a[i] = 32'd0;
            assign exp_a[i] = 1'b0;
        end
    end
endmodule
